// File: rtl/vram_arb.sv
// ---------------------------------------------------------------------------
// vram_arb
//   Arbitrates a single-port screen RAM between the display fetch engine and
//   a host CPU port. The display always wins the memory. Host writes are
//   buffered in a small FIFO and drained on cycles the display leaves free.
//   Host reads wait until every earlier write has reached the RAM, so a read
//   always returns the most recently written value.
//
// Parameters
//   DEPTH  host write FIFO depth in entries (power of two, 2..16)
//   AW     screen memory address width
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   disp_active     display owns the memory this cycle
//   disp_addr       display fetch address
//   host_wr_*       host write request/accept handshake, address and data
//   host_rd_*       host read request/accept handshake and address
//   host_rd_data    last read result, held until the next read completes
//   host_rd_done    one-cycle pulse when host_rd_data carries a new result
//   mem_addr        RAM address
//   mem_wdata       RAM write data
//   mem_we          RAM write enable
//   mem_rdata       RAM read data, one cycle after the address
//   fifo_count      current write FIFO occupancy
// ---------------------------------------------------------------------------
module vram_arb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 13
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          disp_active,
    input  logic [AW-1:0] disp_addr,

    input  logic          host_wr_valid,
    output logic          host_wr_ready,
    input  logic [AW-1:0] host_wr_addr,
    input  logic [7:0]    host_wdata,

    input  logic          host_rd_valid,
    output logic          host_rd_ready,
    input  logic [AW-1:0] host_rd_addr,
    output logic [7:0]    host_rd_data,
    output logic          host_rd_done,

    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,

    output logic [4:0]    fifo_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_CAP
    } state_t;

    state_t          r_state;

    // Write FIFO storage and bookkeeping
    logic [AW-1:0]   r_fifo_addr [DEPTH];
    logic [7:0]      r_fifo_data [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [4:0]      r_count;

    // Read path
    logic [AW-1:0]   r_rd_addr;
    logic [7:0]      r_rd_data;
    logic            r_rd_done;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_rd_acc;
    logic [4:0]      w_count_next;

    logic [AW-1:0]   w_mem_addr;
    logic [7:0]      w_mem_wdata;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    assign w_full        = (r_count == 5'(DEPTH));
    assign w_empty       = (r_count == '0);

    // Ready depends only on occupancy, never on a same-cycle pop, so a full
    // FIFO refuses a write even while the head is being drained.
    assign host_wr_ready = !w_full;
    assign w_push        = host_wr_valid && !w_full;

    // Reads are only offered once all buffered and incoming writes are gone,
    // which keeps read-after-write ordering without an address compare.
    assign host_rd_ready = (r_state == S_IDLE) && w_empty && !host_wr_valid;
    assign w_rd_acc      = host_rd_valid && host_rd_ready;

    // The head leaves only when the RAM is actually written.
    assign w_pop         = (r_state == S_WR) && !disp_active && !w_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 5'd1;
            2'b01:   w_count_next = r_count - 5'd1;
            default: w_count_next = r_count;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= host_wr_addr;
            r_fifo_data[r_wptr] <= host_wdata;
        end
    end

    // Pointers are exactly PW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    assign fifo_count = r_count;

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_WR;
                    end else if (w_rd_acc) begin
                        r_rd_addr <= host_rd_addr;
                        r_state   <= S_RD;
                    end
                end

                // Keep draining while anything remains, including an entry
                // pushed in the same cycle as the last pop.
                S_WR: begin
                    if (w_pop && (w_count_next == '0)) begin
                        r_state <= S_IDLE;
                    end
                end

                // The address goes out on the first free cycle; the RAM
                // answers one cycle later, which is the capture cycle.
                S_RD: begin
                    if (!disp_active) begin
                        r_state   <= S_RD_CAP;
                        r_rd_done <= 1'b1;
                    end
                end

                S_RD_CAP: begin
                    r_rd_data <= mem_rdata;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host_rd_done = r_rd_done;

    // During the capture cycle the fresh RAM word is passed straight through
    // so the data is already valid while host_rd_done is high; afterwards the
    // captured copy holds it.
    assign host_rd_data = (r_state == S_RD_CAP) ? mem_rdata : r_rd_data;

    // -----------------------------------------------------------------------
    // RAM port mux: display first, then the host operation in progress
    // -----------------------------------------------------------------------
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (r_state == S_WR) begin
            w_mem_wdata = r_fifo_data[r_rptr];
        end
        if (disp_active) begin
            w_mem_addr = disp_addr;
        end else begin
            case (r_state)
                S_WR:    w_mem_addr = r_fifo_addr[r_rptr];
                S_RD:    w_mem_addr = r_rd_addr;
                default: w_mem_addr = '0;
            endcase
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign mem_we    = w_pop;

endmodule

// File: tb/tb_vram_arb.sv
// ---------------------------------------------------------------------------
// tb_vram_arb
//   Bench for vram_arb. Holds a behavioural RAM, a reference model (queue of
//   accepted writes, committed memory image, outstanding read) checked every
//   cycle, and a directed sequence with literal expectations.
// ---------------------------------------------------------------------------
module tb_vram_arb;

    localparam int DEPTH = 4;
    localparam int AW    = 13;
    localparam int MSZ   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_active = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [7:0]    host_wdata = '0;
    logic          host_rd_valid = 1'b0;
    logic          host_rd_ready;
    logic [AW-1:0] host_rd_addr = '0;
    logic [7:0]    host_rd_data;
    logic          host_rd_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata = '0;
    logic [4:0]    fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    vram_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_active   (disp_active),
        .disp_addr     (disp_addr),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wdata    (host_wdata),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .host_rd_addr  (host_rd_addr),
        .host_rd_data  (host_rd_data),
        .host_rd_done  (host_rd_done),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM, one-cycle read latency
    logic [7:0] ram    [MSZ];
    logic [7:0] shadow [MSZ];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // -----------------------------------------------------------------------
    // Reference model: accepted writes wait in q, become visible in shadow
    // when written; a read returns shadow at accept time.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t        q[$];
    bit         rd_pend = 1'b0;
    logic [7:0] rd_exp  = '0;
    logic [7:0] exp_rd  = '0;
    int         rd_age  = 0;

    always @(negedge clk) begin
        bit exp_wr_rdy;
        bit exp_rd_rdy;
        wr_t e;
        if (rst) begin
            q.delete();
            rd_pend = 1'b0;
            rd_age  = 0;
            exp_rd  = '0;
            chk("rst_count", fifo_count, 0);
            chk("rst_we",    mem_we, 0);
            chk("rst_done",  host_rd_done, 0);
            chk("rst_rdata", host_rd_data, 0);
        end else begin
            exp_wr_rdy = (q.size() != DEPTH);
            exp_rd_rdy = (q.size() == 0) && !rd_pend && !host_wr_valid;
            chk("count",    fifo_count, q.size());
            chk("wr_ready", host_wr_ready, exp_wr_rdy);
            chk("rd_ready", host_rd_ready, exp_rd_rdy);
            if (disp_active) begin
                chk("disp_addr", mem_addr, disp_addr);
                chk("disp_we",   mem_we, 0);
            end
            if (mem_we) begin
                if (q.size() == 0) begin
                    chk("we_while_empty", mem_we, 0);
                end else begin
                    chk("we_addr", mem_addr, q[0].a);
                    chk("we_data", mem_wdata, q[0].d);
                    shadow[q[0].a] = q[0].d;
                    void'(q.pop_front());
                end
            end
            if (host_rd_done) begin
                chk("done_expected", host_rd_done, rd_pend);
                if (rd_pend) begin
                    chk("rd_data", host_rd_data, rd_exp);
                    exp_rd  = rd_exp;
                    rd_pend = 1'b0;
                end
            end else begin
                chk("rd_data_hold", host_rd_data, exp_rd);
                if (rd_pend) begin
                    rd_age++;
                    if (rd_age > 50) begin
                        chk("rd_timeout", host_rd_done, 1);
                        rd_pend = 1'b0;
                    end
                end
            end
            if (host_wr_valid && exp_wr_rdy) begin
                e.a = host_wr_addr;
                e.d = host_wdata;
                q.push_back(e);
            end
            if (host_rd_valid && exp_rd_rdy) begin
                rd_pend = 1'b1;
                rd_exp  = shadow[host_rd_addr];
                rd_age  = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit         found;
        bit         blocked;
        bit         acc;
        bit         got_done;
        logic [7:0] got_data;

        for (int i = 0; i < MSZ; i++) begin
            ram[i]    = 8'(i) ^ 8'hA5;
            shadow[i] = 8'(i) ^ 8'hA5;
        end
        ram[13'h0100]    = 8'h5A;
        shadow[13'h0100] = 8'h5A;

        // Reset and first cycle afterwards
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t_rst_wr_ready", host_wr_ready, 1);
        chk("t_rst_rd_ready", host_rd_ready, 1);
        chk("t_rst_count",    fifo_count, 0);
        chk("t_rst_rd_data",  host_rd_data, 0);

        // Single write reaches the RAM
        tick();
        host_wr_valid = 1'b1; host_wr_addr = 13'h0042; host_wdata = 8'h41;
        tick();
        host_wr_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (mem_we) begin
                found = 1'b1;
                chk("t036_addr",  mem_addr, 13'h0042);
                chk("t036_wdata", mem_wdata, 8'h41);
            end
        end
        chk("t036_we_seen", found, 1);
        @(negedge clk);
        chk("t036_count", fifo_count, 0);

        // Fill while the display owns the RAM, then drain
        tick();
        disp_active = 1'b1; disp_addr = 13'h0A0B;
        for (int i = 0; i < 5; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = 13'h0010 + 13'(i);
            host_wdata    = 8'hC0 + 8'(i);
            tick();
        end
        host_wr_valid = 1'b0;
        @(negedge clk);
        chk("t037_count_full", fifo_count, 4);
        chk("t037_wr_ready",   host_wr_ready, 0);
        chk("t037_we_stalled", mem_we, 0);
        tick();
        disp_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t037_drain_we",   mem_we, 1);
            chk("t037_drain_addr", mem_addr, 13'h0010 + 13'(i));
            chk("t037_drain_data", mem_wdata, 8'hC0 + 8'(i));
        end
        @(negedge clk);
        chk("t037_drain_end", mem_we, 0);
        chk("t037_count0",    fifo_count, 0);

        // Read latency: done two cycles after accept
        tick();
        host_rd_valid = 1'b1; host_rd_addr = 13'h0100;
        @(negedge clk);
        chk("t038_rd_ready", host_rd_ready, 1);
        tick();
        host_rd_valid = 1'b0;
        @(negedge clk);
        chk("t038_done_c1", host_rd_done, 0);
        @(negedge clk);
        chk("t038_done_c2", host_rd_done, 1);
        chk("t038_data",    host_rd_data, 8'h5A);
        @(negedge clk);
        chk("t038_done_c3", host_rd_done, 0);
        chk("t038_hold",    host_rd_data, 8'h5A);

        // Read behind a write to the same address
        tick();
        host_wr_valid = 1'b1; host_wr_addr = 13'h0200; host_wdata = 8'h77;
        tick();
        host_wr_valid = 1'b0;
        host_rd_valid = 1'b1; host_rd_addr = 13'h0200;
        found = 1'b0; blocked = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (host_rd_ready) begin
                found = 1'b1;
                chk("t039_count_at_accept", fifo_count, 0);
            end else begin
                blocked = 1'b1;
            end
        end
        chk("t039_accepted", found, 1);
        chk("t039_blocked",  blocked, 1);
        tick();
        host_rd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (host_rd_done) begin
                found = 1'b1;
                chk("t039_data", host_rd_data, 8'h77);
            end
        end
        chk("t039_done_seen", found, 1);

        // Display toggling every cycle with writes and a read in between
        tick();
        disp_addr = 13'h0A0B;
        got_done = 1'b0; got_data = '0; acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            disp_active = ~disp_active;
            if (i < 3) begin
                host_wr_valid = 1'b1;
                host_wr_addr  = 13'h0300 + 13'(i);
                host_wdata    = 8'hB0 + 8'(i);
            end else begin
                host_wr_valid = 1'b0;
            end
            if (i == 3) begin
                host_rd_valid = 1'b1; host_rd_addr = 13'h0301;
            end
            @(negedge clk);
            if (disp_active) chk("t040_disp_addr", mem_addr, 13'h0A0B);
            if (host_rd_valid && host_rd_ready) acc = 1'b1;
            if (host_rd_done) begin
                got_done = 1'b1;
                got_data = host_rd_data;
            end
            tick();
            if (acc) host_rd_valid = 1'b0;
        end
        disp_active = 1'b0;
        chk("t040_done_seen", got_done, 1);
        chk("t040_data",      got_data, 8'hB1);
        @(negedge clk);
        chk("t040_count0", fifo_count, 0);

        // Reset while a read is in RD
        tick();
        host_rd_valid = 1'b1; host_rd_addr = 13'h0100;
        tick();
        host_rd_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t041_done",     host_rd_done, 0);
        chk("t041_count",    fifo_count, 0);
        chk("t041_idle",     host_rd_ready, 1);
        chk("t041_rd_data",  host_rd_data, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t041_no_done", host_rd_done, 0);
        end

        // Reset while writes are buffered
        tick();
        disp_active = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = 13'h0400 + 13'(i);
            host_wdata    = 8'hE0 + 8'(i);
            tick();
        end
        host_wr_valid = 1'b0;
        @(negedge clk);
        chk("t034_count_before", fifo_count, 2);
        tick();
        rst = 1'b1;
        #1;
        chk("t034_count_reset", fifo_count, 0);
        tick();
        rst = 1'b0;
        disp_active = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t034_no_we", mem_we, 0);
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter DEPTH, default 4, host write FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter AW, default 13, screen memory address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 disp_active  input  1  display fetch owns memory this cycle.
REQ-006 disp_addr  input  AW  display fetch address (char/colour byte, alternating per cycle).
REQ-007 host_wr_valid  input  1  host write request.
REQ-008 host_wr_ready  output  1  write accepted this cycle when valid and ready are both high.
REQ-009 host_wr_addr  input  AW  write address.
REQ-010 host_wdata  input  8  write data.
REQ-011 host_rd_valid  input  1  host read request.
REQ-012 host_rd_ready  output  1  read accepted this cycle when valid and ready are both high.
REQ-013 host_rd_addr  input  AW  read address.
REQ-014 host_rd_data  output  8  read result, held until next read completes.
REQ-015 host_rd_done  output  1  one-cycle pulse, host_rd_data valid.
REQ-016 mem_addr  output  AW  single-port screen RAM address.
REQ-017 mem_wdata  output  8  RAM write data.
REQ-018 mem_we  output  1  RAM write enable.
REQ-019 mem_rdata  input  8  RAM read data, one-cycle synchronous latency.
REQ-020 fifo_count  output  5  current write FIFO occupancy.

Function
REQ-021 Display has absolute priority: when disp_active=1, mem_addr SHALL equal disp_addr combinationally and mem_we SHALL be 0.
REQ-022 Host writes enter a DEPTH-entry FIFO of {addr, data}; host_wr_ready SHALL equal (fifo_count != DEPTH), independent of a same-cycle pop.
REQ-023 FSM states IDLE, WR, RD, RD_CAP; reset state IDLE.
REQ-024 IDLE: FIFO non-empty -> WR; else host_rd_valid & host_rd_ready -> RD, latching host_rd_addr; else stay.
REQ-025 host_rd_ready SHALL be 1 only in IDLE with fifo_count=0 and host_wr_valid=0 (writes ahead of reads; read-after-write ordering preserved).
REQ-026 WR: mem_addr/mem_wdata SHALL present FIFO head; on a cycle with disp_active=0, mem_we=1 and head pops; stay WR while entries remain after pop, else IDLE.
REQ-027 WR with disp_active=1: no pop, no write, stay WR (stall, no data loss).
REQ-028 RD: mem_addr SHALL present latched read address when disp_active=0, then -> RD_CAP; with disp_active=1 stay RD.
REQ-029 RD_CAP: host_rd_data <= mem_rdata, host_rd_done=1 for exactly this cycle, -> IDLE; mem_we=0; mem_addr follows REQ-021 if disp_active, else don't-care.
REQ-030 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-031 Push when full SHALL be ignored (ready already 0); pop when empty SHALL not occur.
REQ-032 mem_we SHALL never be 1 outside WR.

Reset
REQ-033 On rst=1, immediately: state IDLE, FIFO empty (fifo_count=0), host_rd_data=0, host_rd_done=0, mem_we=0, latched read address 0.
REQ-034 Reset mid-write or mid-read SHALL discard all pending FIFO entries and any in-flight read; no host_rd_done pulse follows.
REQ-035 After rst deasserts, host_wr_ready=1 and host_rd_ready=1 (with host_wr_valid=0) on the first cycle.

Verification
REQ-036 disp_active=0, write {0x0042, 0x41} -> WR next cycle, mem_we=1 with mem_addr=0x0042, mem_wdata=0x41; fifo_count back to 0.
REQ-037 disp_active=1 throughout, push 4 writes -> fifo_count=4, host_wr_ready=0, mem_we never 1; drop disp_active -> 4 consecutive mem_we cycles in push order.
REQ-038 FIFO empty, read 0x0100 with RAM holding 0x5A, disp_active=0 -> host_rd_done pulse exactly 2 cycles after accept, host_rd_data=0x5A.
REQ-039 Write 0x0200<=0x77 then read 0x0200 next cycle -> read not accepted until FIFO empty; returned data=0x77.
REQ-040 disp_active toggling every cycle with disp_addr=0x0A0B -> mem_addr=0x0A0B on every active cycle; host operations progress only on inactive cycles.
REQ-041 rst asserted in RD state -> host_rd_done stays 0, fifo_count=0, state IDLE immediately.
